// File: rtl/sync_dualport_ram_sweep.sv
// Single-clock simple dual-port RAM with byte enables, write-first bypass,
// registered read with valid/error flags and a hardware clear-sweep FSM.
module sync_dualport_ram_sweep #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4,
    parameter int BYTE_W = 8,
    localparam int NB    = WIDTH / BYTE_W
) (
    input  logic              clk_i,
    input  logic              clr_n_i,
    input  logic              init_i,
    input  logic              write_i,
    input  logic [NB-1:0]     wr_be_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  data_in_i,
    input  logic              read_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  data_out_o,
    output logic              rd_valid_o,
    output logic              rd_err_o,
    output logic              wr_err_o,
    output logic              busy_o
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        SWEEP,
        READY
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_err_q, rd_err_d;
    logic               wr_err_q, wr_err_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               sweep_we;
    logic               wr_acc, rd_acc;
    logic               wr_in_range, rd_in_range;
    logic               wr_ok;
    logic [IDX_W-1:0]   wr_idx, rd_idx, ptr_idx;
    logic [WIDTH-1:0]   wr_word, rd_word;

    assign wr_in_range = {1'b0, wr_addr_i} < DEPTH_A;
    assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_A;
    assign wr_idx      = wr_addr_i[IDX_W-1:0];
    assign rd_idx      = rd_addr_i[IDX_W-1:0];
    assign ptr_idx     = ptr_q[IDX_W-1:0];
    assign wr_ok       = wr_acc && wr_in_range;

    // init wins over port accesses; an init during a sweep just rewinds the pointer
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_we = 1'b0;
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        case (state_q)
            SWEEP: begin
                if (init_i) begin
                    ptr_d = '0;
                end else begin
                    sweep_we = 1'b1;
                    if (ptr_q == LAST) begin
                        state_d = READY;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            READY: begin
                if (init_i) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else begin
                    wr_acc = write_i;
                    rd_acc = read_i;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_word = mem_q[wr_idx];
        for (int k = 0; k < NB; k++) begin
            if (wr_be_i[k]) begin
                wr_word[k*BYTE_W +: BYTE_W] = data_in_i[k*BYTE_W +: BYTE_W];
            end
        end
        rd_word = (wr_ok && (wr_addr_i == rd_addr_i)) ? wr_word : mem_q[rd_idx];
    end

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_acc;
        rd_err_d   = rd_acc && !rd_in_range;
        wr_err_d   = wr_acc && !wr_in_range;
        if (rd_acc) begin
            data_out_d = rd_in_range ? rd_word : '0;
        end
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q    <= SWEEP;
            ptr_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Storage has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            mem_q[ptr_idx] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    assign data_out_o = data_out_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign wr_err_o   = wr_err_q;
    assign busy_o     = (state_q == SWEEP);

endmodule

// File: tb/tb_sync_dualport_ram_sweep.sv
// Directed testbench for sync_dualport_ram_sweep: a DEPTH=8 instance for most
// scenarios and a DEPTH=6 instance sharing the same stimulus for range checks.
module tb_sync_dualport_ram_sweep;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        init;
    logic        write;
    logic [1:0]  wr_be;
    logic [3:0]  wr_addr;
    logic [15:0] data_in;
    logic        read;
    logic [3:0]  rd_addr;

    logic [15:0] dout8, dout6;
    logic        rv8, rv6, re8, re6, we8, we6, busy8, busy6;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sync_dualport_ram_sweep #(.WIDTH(16), .DEPTH(8), .ADDR_W(4), .BYTE_W(8)) dut8 (
        .clk_i(clk), .clr_n_i(clr_n), .init_i(init), .write_i(write), .wr_be_i(wr_be),
        .wr_addr_i(wr_addr), .data_in_i(data_in), .read_i(read), .rd_addr_i(rd_addr),
        .data_out_o(dout8), .rd_valid_o(rv8), .rd_err_o(re8), .wr_err_o(we8), .busy_o(busy8)
    );

    sync_dualport_ram_sweep #(.WIDTH(16), .DEPTH(6), .ADDR_W(4), .BYTE_W(8)) dut6 (
        .clk_i(clk), .clr_n_i(clr_n), .init_i(init), .write_i(write), .wr_be_i(wr_be),
        .wr_addr_i(wr_addr), .data_in_i(data_in), .read_i(read), .rd_addr_i(rd_addr),
        .data_out_o(dout6), .rd_valid_o(rv6), .rd_err_o(re6), .wr_err_o(we6), .busy_o(busy6)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [3:0] wa, input logic [15:0] d,
                                 input logic [1:0] be, input logic r, input logic [3:0] ra);
        write   = w;
        wr_addr = wa;
        data_in = d;
        wr_be   = be;
        read    = r;
        rd_addr = ra;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        init = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        idle();
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b1 || dout8 !== 16'h0 || rv8 !== 1'b0 || re8 !== 1'b0 || we8 !== 1'b0)
            $display("[TB] FAIL reset_outputs: got busy=%b dout=%h rv=%b re=%b we=%b want 1 0000 0 0 0",
                     busy8, dout8, rv8, re8, we8);
        else passes++;
        clr_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy8 !== 1'b1) $display("[TB] FAIL reset_busy_%0d: got %b want 1", i, busy8);
            else passes++;
            tick();
        end
        checks++;
        if (busy8 !== 1'b0) $display("[TB] FAIL reset_busy_end: got %b want 0", busy8);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            tick();
            checks++;
            if (dout8 !== 16'h0 || rv8 !== 1'b1 || re8 !== 1'b0)
                $display("[TB] FAIL reset_read_%0d: got dout=%h rv=%b re=%b want 0000 1 0", i, dout8, rv8, re8);
            else passes++;
        end
        idle();
        tick();
        checks++;
        if (rv8 !== 1'b0) $display("[TB] FAIL reset_rv_drop: got %b want 0", rv8);
        else passes++;
    endtask

    task automatic test_range();
        applyStimulus(1'b1, 4'd2, 16'h1357, 2'b11, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b0, 4'd0);
        tick();
        idle();
        checks++;
        if (we6 !== 1'b1 || we8 !== 1'b0)
            $display("[TB] FAIL range_wr_err: got d6=%b d8=%b want 1 0", we6, we8);
        else passes++;
        tick();
        checks++;
        if (we6 !== 1'b0) $display("[TB] FAIL range_wr_err_pulse: got %b want 0", we6);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            tick();
            checks++;
            if (dout6 !== ((i == 2) ? 16'h1357 : 16'h0000) || rv6 !== 1'b1 || re6 !== 1'b0)
                $display("[TB] FAIL range_contents_%0d: got dout=%h rv=%b re=%b want %h 1 0",
                         i, dout6, rv6, re6, (i == 2) ? 16'h1357 : 16'h0000);
            else passes++;
        end
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd6);
        tick();
        checks++;
        if (dout6 !== 16'h0 || rv6 !== 1'b1 || re6 !== 1'b1)
            $display("[TB] FAIL range_rd_err: got dout=%h rv=%b re=%b want 0000 1 1", dout6, rv6, re6);
        else passes++;
        idle();
        tick();
        checks++;
        if (rv6 !== 1'b0 || re6 !== 1'b0 || dout6 !== 16'h0)
            $display("[TB] FAIL range_rd_idle: got dout=%h rv=%b re=%b want 0000 0 0", dout6, rv6, re6);
        else passes++;
    endtask

    task automatic test_byte_enable();
        applyStimulus(1'b1, 4'd3, 16'hA5A5, 2'b11, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0);
        tick();
        checks++;
        if (rv8 !== 1'b0) $display("[TB] FAIL be_no_valid: got %b want 0", rv8);
        else passes++;
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        tick();
        idle();
        checks++;
        if (dout8 !== 16'hA534 || rv8 !== 1'b1)
            $display("[TB] FAIL be_merge: got dout=%h rv=%b want a534 1", dout8, rv8);
        else passes++;
        applyStimulus(1'b1, 4'd3, 16'h9999, 2'b00, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        tick();
        idle();
        checks++;
        if (dout8 !== 16'hA534) $display("[TB] FAIL be_zero_noop: got %h want a534", dout8);
        else passes++;
    endtask

    task automatic test_bypass();
        applyStimulus(1'b1, 4'd5, 16'h00FF, 2'b11, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b1, 4'd5, 16'hBEEF, 2'b10, 1'b1, 4'd5);
        tick();
        checks++;
        if (dout8 !== 16'hBEFF || rv8 !== 1'b1)
            $display("[TB] FAIL bypass_same: got dout=%h rv=%b want beff 1", dout8, rv8);
        else passes++;
        applyStimulus(1'b1, 4'd1, 16'h4321, 2'b11, 1'b1, 4'd3);
        tick();
        checks++;
        if (dout8 !== 16'hA534) $display("[TB] FAIL bypass_diff_read: got %h want a534", dout8);
        else passes++;
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1);
        tick();
        checks++;
        if (dout8 !== 16'h4321) $display("[TB] FAIL bypass_diff_write: got %h want 4321", dout8);
        else passes++;
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        tick();
        idle();
        checks++;
        if (dout8 !== 16'hBEFF) $display("[TB] FAIL bypass_stored: got %h want beff", dout8);
        else passes++;
    endtask

    task automatic test_init();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i), 16'hFFFF, 2'b11, 1'b0, 4'd0);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd4);
        tick();
        checks++;
        if (dout8 !== 16'hFFFF) $display("[TB] FAIL init_fill: got %h want ffff", dout8);
        else passes++;
        init = 1'b1;
        applyStimulus(1'b1, 4'd2, 16'h5555, 2'b11, 1'b1, 4'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            init = 1'b0;
            checks++;
            if (busy8 !== 1'b1 || rv8 !== 1'b0 || dout8 !== 16'hFFFF)
                $display("[TB] FAIL init_busy_%0d: got busy=%b rv=%b dout=%h want 1 0 ffff", i, busy8, rv8, dout8);
            else passes++;
        end
        tick();
        checks++;
        if (busy8 !== 1'b0 || rv8 !== 1'b0)
            $display("[TB] FAIL init_busy_end: got busy=%b rv=%b want 0 0", busy8, rv8);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            tick();
            checks++;
            if (dout8 !== 16'h0 || rv8 !== 1'b1)
                $display("[TB] FAIL init_cleared_%0d: got dout=%h rv=%b want 0000 1", i, dout8, rv8);
            else passes++;
        end
        idle();
        tick();
    endtask

    task automatic test_midsweep_reset();
        applyStimulus(1'b1, 4'd0, 16'hCAFE, 2'b11, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
        tick();
        idle();
        checks++;
        if (dout8 !== 16'hCAFE) $display("[TB] FAIL mid_pre: got %h want cafe", dout8);
        else passes++;
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        clr_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b1 || dout8 !== 16'h0 || rv8 !== 1'b0 || re8 !== 1'b0 || we8 !== 1'b0)
            $display("[TB] FAIL mid_async: got busy=%b dout=%h rv=%b re=%b we=%b want 1 0000 0 0 0",
                     busy8, dout8, rv8, re8, we8);
        else passes++;
        tick();
        tick();
        clr_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy8 !== 1'b1) $display("[TB] FAIL mid_busy_%0d: got %b want 1", i, busy8);
            else passes++;
            tick();
        end
        checks++;
        if (busy8 !== 1'b0) $display("[TB] FAIL mid_busy_end: got %b want 0", busy8);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_range();
        test_byte_enable();
        test_bypass();
        test_init();
        test_midsweep_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
